// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants and the retirement trace record
// Purpose: XLEN, the canonical NOP and flushed-PC markers, and retire_rec_t,
//          the record captured per retired instruction.
// Ports: none (package).
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RV_NOP     = 32'h0000_0013;
  // PC value the core drives on a flushed (bubble) retire slot
  localparam logic [XLEN-1:0] PC_FLUSHED = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0]     seq;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_wrt;
  } retire_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - generic synchronous FIFO with occupancy output
// Purpose: DEPTH-entry FIFO of elem_t; pointers carry one extra wrap bit.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (pointers only)
//   push_i, data_i   write request and data; accepted when not full, or
//                    when full and a pop happens in the same cycle
//   pop_i            read request; ignored while empty
//   data_o           head entry (don't-care while empty)
//   full_o, empty_o  status, derived only from the pointers
//   level_o          occupancy, 0..DEPTH
module trace_fifo #(
  parameter int  DEPTH  = 16,
  parameter type elem_t = logic [7:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  elem_t                  data_i,
  input  logic                   pop_i,
  output elem_t                  data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  elem_t       mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // Same slot index, opposite lap: the writer is one full lap ahead.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - retire-port trace capture FIFO with drop statistics
// Purpose: forms one retire_rec_t per retire strobe, tags it with a 32-bit
//          sequence number, buffers it and drains it over valid/ready.
//          Records arriving while full are dropped and counted, never stalling
//          the core.
// Optional feature: define TRACE_BUBBLE_FILTER_EN to discard flushed slots
//          (pc == PC_FLUSHED) and NOPs before capture (no seq, no drop).
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   update_i                   retire strobe
//   pc_i, instr_i, reg_addr_i, reg_data_i, mem_addr_i, mem_data_i, mem_wrt_i
//                              retire port fields
//   out_valid_o, out_ready_i   head handshake; out_rec_o is the head record
//   level_o                    FIFO occupancy
//   drop_cnt_o, overflow_o     saturating drop count, sticky overflow flag
//   clr_stat_i                 clears drop_cnt_o and overflow_o
module retire_trace_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   update_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        instr_i,
  input  logic [4:0]             reg_addr_i,
  input  logic [XLEN-1:0]        reg_data_i,
  input  logic [XLEN-1:0]        mem_addr_i,
  input  logic [XLEN-1:0]        mem_data_i,
  input  logic                   mem_wrt_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output retire_rec_t            out_rec_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [DROP_W-1:0]      drop_cnt_o,
  output logic                   overflow_o,
  input  logic                   clr_stat_i
);

  logic [31:0]       seq_q, seq_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;

  logic        filtered, capture, pop, drop;
  logic        fifo_full, fifo_empty;
  retire_rec_t rec;

  assign out_valid_o = ~fifo_empty;
  assign drop_cnt_o  = drop_cnt_q;
  assign overflow_o  = overflow_q;

  always_comb begin
`ifdef TRACE_BUBBLE_FILTER_EN
    filtered = (pc_i == PC_FLUSHED) || (instr_i == RV_NOP);
`else
    filtered = 1'b0;
`endif
    capture = update_i & ~filtered;
    pop     = out_valid_o & out_ready_i;
    drop    = capture & fifo_full & ~pop;

    rec.seq      = seq_q;
    rec.pc       = pc_i;
    rec.instr    = instr_i;
    rec.rd       = reg_addr_i;
    rec.rd_data  = reg_data_i;
    rec.mem_addr = mem_addr_i;
    rec.mem_data = mem_data_i;
    rec.mem_wrt  = mem_wrt_i;

    // seq advances on dropped records too, so the consumer sees the gap.
    seq_d      = seq_q + {31'b0, capture};
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (clr_stat_i) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      if (drop_cnt_q != {DROP_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  trace_fifo #(
    .DEPTH  (DEPTH),
    .elem_t (retire_rec_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (capture),
    .data_i  (rec),
    .pop_i   (out_ready_i),
    .data_o  (out_rec_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - self-checking bench for retire_trace_buffer
module tb_retire_trace_buffer;
  import riscv_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              update_i = 1'b0;
  logic [XLEN-1:0]   pc_i = '0;
  logic [XLEN-1:0]   instr_i = '0;
  logic [4:0]        reg_addr_i = '0;
  logic [XLEN-1:0]   reg_data_i = '0;
  logic [XLEN-1:0]   mem_addr_i = '0;
  logic [XLEN-1:0]   mem_data_i = '0;
  logic              mem_wrt_i = 1'b0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  retire_rec_t       out_rec_o;
  logic [LW-1:0]     level_o;
  logic [DROP_W-1:0] drop_cnt_o;
  logic              overflow_o;
  logic              clr_stat_i = 1'b0;

  always #5 clk = ~clk;

  retire_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .update_i    (update_i),
    .pc_i        (pc_i),
    .instr_i     (instr_i),
    .reg_addr_i  (reg_addr_i),
    .reg_data_i  (reg_data_i),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .mem_wrt_i   (mem_wrt_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_rec_o   (out_rec_o),
    .level_o     (level_o),
    .drop_cnt_o  (drop_cnt_o),
    .overflow_o  (overflow_o),
    .clr_stat_i  (clr_stat_i)
  );

  typedef struct {
    logic        rst;
    logic        upd;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rdy;
    logic        clr;
    int          exp_level;
    int          exp_drop;
    logic        exp_ovf;
    logic        exp_valid;
  } vec_t;

  vec_t        vecs[$];
  retire_rec_t sb[$];
  logic [31:0] mseq = '0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // R-type opcode in the low bits, so never equal to the NOP encoding
  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom();
    return (r & 32'hFFFF_FF80) | 32'h0000_0033;
  endfunction

  function automatic bit is_bubble(input logic [31:0] pc, input logic [31:0] instr);
`ifdef TRACE_BUBBLE_FILTER_EN
    return (pc == PC_FLUSHED) || (instr == RV_NOP);
`else
    return 1'b0 && (pc == instr);
`endif
  endfunction

  // Drive one cycle; the scoreboard checks the head on every pop and records
  // every pushed record.
  task automatic apply(input logic rst, input logic upd, input logic [31:0] pc,
                       input logic [31:0] instr, input logic rdy, input logic clr);
    retire_rec_t r;
    rst_i       = rst;
    update_i    = upd;
    pc_i        = pc;
    instr_i     = instr;
    reg_addr_i  = 5'($urandom());
    reg_data_i  = $urandom();
    mem_addr_i  = $urandom();
    mem_data_i  = $urandom();
    mem_wrt_i   = 1'($urandom());
    out_ready_i = rdy;
    clr_stat_i  = clr;
    if (rst) begin
      sb.delete();
      mseq = '0;
    end else begin
      if (rdy && sb.size() > 0) begin
        chk("pop_valid", {63'b0, out_valid_o}, 64'd1);
        n_total++;
        if (out_rec_o === sb[0]) n_pass++;
        else $display("FAIL pop_rec: got seq %0d pc 0x%08h rec 0x%0h expected seq %0d pc 0x%08h rec 0x%0h",
                      out_rec_o.seq, out_rec_o.pc, out_rec_o, sb[0].seq, sb[0].pc, sb[0]);
        void'(sb.pop_front());
      end
      if (upd && !is_bubble(pc, instr)) begin
        r.seq      = mseq;
        r.pc       = pc;
        r.instr    = instr;
        r.rd       = reg_addr_i;
        r.rd_data  = reg_data_i;
        r.mem_addr = mem_addr_i;
        r.mem_data = mem_data_i;
        r.mem_wrt  = mem_wrt_i;
        mseq++;
        if (sb.size() < DEPTH) sb.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic rst, input logic upd, input logic [31:0] pc, input logic rdy,
                         input logic clr, input int lvl, input int drp, input logic ovf);
    vec_t v;
    v.rst = rst; v.upd = upd; v.pc = pc; v.instr = rnd_instr(); v.rdy = rdy; v.clr = clr;
    v.exp_level = lvl; v.exp_drop = drp; v.exp_ovf = ovf; v.exp_valid = (lvl > 0);
    vecs.push_back(v);
  endtask

  task automatic drain_all();
    for (int i = 0; i < DEPTH + 2; i++) apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain_level", 64'(level_o), 64'd0);
  endtask

  initial begin
    // Basic capture then drain
    add_vec(1, 0, 32'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add_vec(0, 1, 32'(4 * i), 0, 0, i + 1, 0, 0);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 32'h0, 1, 0, 2 - i, 0, 0);
    // Overflow: 20 strobes into 16 entries
    add_vec(1, 0, 32'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      add_vec(0, 1, 32'h100 + 32'(4 * i), 0, 0, (i < 16) ? i + 1 : 16, (i < 16) ? 0 : i - 15, i >= 16);
    // Full with strobe and ready together: no drop, level unchanged
    add_vec(0, 1, 32'h500, 1, 0, 16, 4, 1);
    for (int i = 0; i < 16; i++) add_vec(0, 0, 32'h0, 1, 0, 15 - i, 4, 1);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].upd, vecs[i].pc, vecs[i].instr, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("v%0d_level", i), 64'(level_o), 64'(vecs[i].exp_level));
      chk($sformatf("v%0d_drop", i), 64'(drop_cnt_o), 64'(vecs[i].exp_drop));
      chk($sformatf("v%0d_ovf", i), {63'b0, overflow_o}, {63'b0, vecs[i].exp_ovf});
      chk($sformatf("v%0d_valid", i), {63'b0, out_valid_o}, {63'b0, vecs[i].exp_valid});
    end

    // Head held while not ready
    apply(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 1, 32'(4 * i), rnd_instr(), 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    chk("hold_head_pc", 64'(out_rec_o.pc), 64'h0);
    chk("hold_head_seq", 64'(out_rec_o.seq), 64'd0);
    chk("hold_level", 64'(level_o), 64'd3);
    drain_all();

    // Clear coinciding with a drop, then saturation
    apply(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) apply(0, 1, 32'h1000 + 32'(4 * i), rnd_instr(), 0, 0);
    chk("pre_clr_drop", 64'(drop_cnt_o), 64'd1);
    apply(0, 1, 32'h2000, rnd_instr(), 0, 1);
    chk("clr_drop", 64'(drop_cnt_o), 64'd0);
    chk("clr_ovf", {63'b0, overflow_o}, 64'd0);
    chk("clr_level", 64'(level_o), 64'd16);
    apply(0, 1, 32'h2004, rnd_instr(), 0, 0);
    chk("post_clr_drop", 64'(drop_cnt_o), 64'd1);
    chk("post_clr_ovf", {63'b0, overflow_o}, 64'd1);
    for (int i = 0; i < 20; i++) apply(0, 1, 32'h3000 + 32'(4 * i), rnd_instr(), 0, 0);
    chk("sat_drop", 64'(drop_cnt_o), 64'd15);
    apply(0, 0, 0, 0, 0, 1);
    chk("clr_only_drop", 64'(drop_cnt_o), 64'd0);
    chk("clr_only_ovf", {63'b0, overflow_o}, 64'd0);
    drain_all();

    // Reset mid-operation
    apply(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply(0, 1, 32'h4000 + 32'(4 * i), rnd_instr(), 0, 0);
    chk("mid_level5", 64'(level_o), 64'd5);
    apply(1, 0, 0, 0, 0, 0);
    chk("mid_rst_level", 64'(level_o), 64'd0);
    chk("mid_rst_valid", {63'b0, out_valid_o}, 64'd0);
    apply(0, 1, 32'h300, rnd_instr(), 0, 0);
    chk("after_rst_seq", 64'(out_rec_o.seq), 64'd0);
    chk("after_rst_pc", 64'(out_rec_o.pc), 64'h300);
    chk("after_rst_level", 64'(level_o), 64'd1);
    drain_all();

`ifdef TRACE_BUBBLE_FILTER_EN
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 1, 32'h200, RV_NOP, 0, 0);
    apply(0, 1, PC_FLUSHED, rnd_instr(), 0, 0);
    apply(0, 1, 32'h204, 32'h0010_0093, 0, 0);
    chk("filt_level", 64'(level_o), 64'd1);
    chk("filt_seq", 64'(out_rec_o.seq), 64'd0);
    chk("filt_pc", 64'(out_rec_o.pc), 64'h204);
    chk("filt_drop", 64'(drop_cnt_o), 64'd0);
    drain_all();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Captures one retirement record per `update_i` strobe from the pipelined RV32I core's retire port. Records go into a small synchronous FIFO and drain to a trace consumer (logger, UART bridge, or testbench scoreboard) over a valid/ready handshake. The block sits directly downstream of the core's retire outputs. It decouples trace draining from core execution, and it counts records lost to overflow instead of stalling the core.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `DROP_W`, 16: width of the saturating drop counter.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- `update_i`  in  1  retire strobe; one record is captured per cycle it is high.
- `pc_i`  in  XLEN  retired PC.
- `instr_i`  in  XLEN  retired instruction.
- `reg_addr_i`  in  5  destination register.
- `reg_data_i`  in  XLEN  register write data.
- `mem_addr_i`  in  XLEN  memory address.
- `mem_data_i`  in  XLEN  memory write data.
- `mem_wrt_i`  in  1  memory write enable.
- `out_valid_o`  out  1  head record available.
- `out_ready_i`  in  1  consumer accepts the head record.
- `out_rec_o`  out  `retire_rec_t`  head record.
- `level_o`  out  $clog2(DEPTH)+1  occupancy.
- `drop_cnt_o`  out  DROP_W  records lost to full FIFO; saturating.
- `overflow_o`  out  1  sticky; set on the first drop.
- `clr_stat_i`  in  1  clears `drop_cnt_o` and `overflow_o`.

## Operation
- Capture: when `update_i`=1 (and the record is not filtered), a record is formed.
  - Record fields: all retire inputs plus `seq`, a 32-bit retire sequence number.
- `seq` counter: starts at 0 and increments on every captured record, whether it is stored or dropped, so the consumer can see gaps. Wraps at 2^32.
- Push: the record is written at `wr_ptr` when the FIFO is not full, or when it is full and a pop happens in the same cycle.
- Drop: otherwise the record is discarded, `drop_cnt_o` increments (saturating at all-ones), and `overflow_o` sets.
- Pop: occurs when `out_valid_o & out_ready_i`; `rd_ptr` advances.
- Pointers: `$clog2(DEPTH)+1` bits, wrapping naturally.
  - Empty when `wr_ptr == rd_ptr`.
  - Full when the pointers differ only in their MSB.
- `out_valid_o` = not empty. `out_rec_o` is read from storage at `rd_ptr` and holds stable while valid and not ready.
- `out_rec_o` content while empty is don't-care; the bench must not check it.
- Simultaneous push and pop:
  - When empty: the push proceeds; no pop occurs because valid is low.
  - When full: both proceed; level is unchanged and there is no drop.
  - Otherwise: level is unchanged.
- `clr_stat_i` coinciding with a drop: clear wins, and the counter ends at 0.
- Reset mid-operation: the FIFO contents are discarded, and no partial record is emitted.

## Timing
- Reset values:
  - `out_valid_o`=0, `level_o`=0, `drop_cnt_o`=0, `overflow_o`=0.
  - `seq` = 0; pointers = 0.
  - Storage is not reset.
- Latency: a record captured at edge N gives `out_valid_o`=1 and `out_rec_o` valid after edge N, meaning it is visible in the cycle after the strobe.
- `level_o` and the stats update at the same edge as the push, pop, or drop.
- Throughput: one push and one pop per cycle sustained.
- No combinational path from `update_i` to any output. `out_valid_o` depends only on the pointers.

## Configuration
- `TRACE_BUBBLE_FILTER_EN`, when defined: records are discarded before capture and are neither counted in `seq` nor treated as drops when either:
  - `pc_i` = 32'hFFFFFFFF (the flushed marker), or
  - `instr_i` = `RV_NOP` (32'h00000013).
- Without the macro: every `update_i` cycle is captured.

## Structure
- `riscv_pkg` additions:
  - `retire_rec_t` packed struct: `seq`[31:0], `pc`, `instr`, `rd`[4:0], `rd_data`, `mem_addr`, `mem_data`, `mem_wrt`.
  - `RV_NOP` constant.
  - `PC_FLUSHED` constant (32'hFFFFFFFF).
- Sub-module `trace_fifo`: a generic synchronous FIFO parameterised on `DEPTH` and element type. It exposes push, pop, full, empty and level.
- `retire_trace_buffer` holds the record formation, `seq` counter, drop statistics and filter.

## Test plan
- Reset, then 3 strobes with pc 0x0, 0x4, 0x8 and `out_ready_i`=0 → level 3, head pc 0x0 seq 0. Raising ready drains pc 0x0/0x4/0x8 with seq 0/1/2 on consecutive cycles.
- DEPTH=16, ready=0, 20 strobes → level 16, `drop_cnt_o`=4, `overflow_o`=1. The drained records are seq 0–15; the next accepted record has seq 20.
- Full FIFO with strobe and ready in the same cycle → level stays 16, no drop, and the new record lands at the tail.
- `clr_stat_i` asserted in the same cycle as a drop → `drop_cnt_o`=0 and `overflow_o`=0 on the next cycle.
- `rst_i` pulsed with level 5 → next cycle level 0, `out_valid_o`=0; the next strobe gets seq 0.
- With `TRACE_BUBBLE_FILTER_EN`: strobes with instr 0x00000013, pc 0xFFFFFFFF, then a valid addi → only the addi is stored, with seq 0 and `drop_cnt_o`=0.
